// File: rtl/tts_state_tracker.sv
// Registered TTS status generator: debounces error/sync/busy/overflow requests,
// latches errors until cleared and holds each state a minimum dwell before de-escalating.
module tts_state_tracker #(
    parameter int N_ERR      = 5,
    parameter int N_SYNC     = 4,
    parameter int N_OVF      = 1,
    parameter int DEBOUNCE   = 4,
    parameter int MIN_HOLD   = 1024,
    parameter int ERR_STICKY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_ERR-1:0]  error_in,
    input  logic [N_SYNC-1:0] sync_lost_in,
    input  logic              busy_in,
    input  logic [N_OVF-1:0]  ovf_warn_in,
    input  logic              clear,
    output logic [3:0]        tts_state,
    output logic [N_ERR-1:0]  err_cause,
    output logic [15:0]       transition_count
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);

    typedef enum logic [3:0] {
        TTS_DISC  = 4'b0000,
        TTS_READY = 4'b1000,
        TTS_OVF   = 4'b0001,
        TTS_BUSY  = 4'b0100,
        TTS_SYNC  = 4'b0010,
        TTS_ERROR = 4'b1100
    } tts_e;

    // Category index: 0 error, 1 sync-lost, 2 busy, 3 overflow warning.
    logic [3:0]          raw;
    logic [3:0]          active;
    logic [3:0][DW-1:0]  deb_cnt;
    logic                err_hold;
    logic                err_flag;
    logic [N_ERR-1:0]    err_seen;
    logic [HW-1:0]       dwell;
    tts_e                state;
    tts_e                target;
    logic                escalate;
    logic                deescalate;
    logic                change;

    assign raw = {|ovf_warn_in, busy_in, |sync_lost_in, |error_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!raw[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_MAX)
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < 4; i++)
            active[i] = (deb_cnt[i] == DEB_MAX);
    end

    // A clear is only honoured once the raw error request has gone away.
    generate
        if (ERR_STICKY != 0) begin : g_sticky
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    err_hold <= 1'b0;
                else if (clear && !raw[0])
                    err_hold <= 1'b0;
                else if (active[0])
                    err_hold <= 1'b1;
            end
        end else begin : g_follow
            assign err_hold = 1'b0;
        end
    endgenerate

    assign err_flag = err_hold | active[0];
    assign err_seen = err_flag ? error_in : '0;

    function automatic logic [2:0] rank_of(input tts_e s);
        case (s)
            TTS_ERROR: rank_of = 3'd5;
            TTS_SYNC:  rank_of = 3'd4;
            TTS_BUSY:  rank_of = 3'd3;
            TTS_OVF:   rank_of = 3'd2;
            TTS_READY: rank_of = 3'd1;
            default:   rank_of = 3'd0;
        endcase
    endfunction

    always_comb begin
        target = TTS_READY;
        if (err_flag)
            target = TTS_ERROR;
        else if (active[1])
            target = TTS_SYNC;
        else if (active[2])
            target = TTS_BUSY;
        else if (active[3])
            target = TTS_OVF;
    end

    assign escalate   = rank_of(target) > rank_of(state);
    assign deescalate = (rank_of(target) < rank_of(state)) && (dwell == '0);
    assign change     = escalate | deescalate;

    // Escalation is immediate; stepping down waits for the dwell counter to drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TTS_DISC;
            dwell <= '0;
        end else if (change) begin
            state <= target;
            dwell <= HOLD_LOAD;
        end else if (dwell != '0) begin
            dwell <= dwell - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            transition_count <= '0;
        else if (clear)
            transition_count <= change ? 16'd1 : 16'd0;
        else if (change && transition_count != 16'hFFFF)
            transition_count <= transition_count + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cause <= '0;
        else if (clear)
            err_cause <= err_seen;
        else
            err_cause <= err_cause | err_seen;
    end

    assign tts_state = state;

endmodule

// File: tb/tb_tts_state_tracker.sv
// Bench for tts_state_tracker: three parameterisations share one stimulus stream and are
// compared each cycle against a rank/age reference model, plus a hand-derived vector table.
module tb_tts_state_tracker;

    logic        clk;
    logic        reset_n;
    logic [4:0]  error_in;
    logic [3:0]  sync_lost_in;
    logic        busy_in;
    logic [0:0]  ovf_warn_in;
    logic        clear;

    logic [3:0]  tts_a, tts_b, tts_c;
    logic [4:0]  cause_a, cause_b, cause_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int total = 0;
    int bad   = 0;

    // a: sticky errors, b: errors follow input, c: no debounce/no dwell for saturation runs.
    tts_state_tracker #(.N_ERR(5), .N_SYNC(4), .N_OVF(1), .DEBOUNCE(4), .MIN_HOLD(8), .ERR_STICKY(1)) u_sticky (
        .clk(clk), .reset_n(reset_n), .error_in(error_in), .sync_lost_in(sync_lost_in),
        .busy_in(busy_in), .ovf_warn_in(ovf_warn_in), .clear(clear),
        .tts_state(tts_a), .err_cause(cause_a), .transition_count(cnt_a));

    tts_state_tracker #(.N_ERR(5), .N_SYNC(4), .N_OVF(1), .DEBOUNCE(4), .MIN_HOLD(8), .ERR_STICKY(0)) u_follow (
        .clk(clk), .reset_n(reset_n), .error_in(error_in), .sync_lost_in(sync_lost_in),
        .busy_in(busy_in), .ovf_warn_in(ovf_warn_in), .clear(clear),
        .tts_state(tts_b), .err_cause(cause_b), .transition_count(cnt_b));

    tts_state_tracker #(.N_ERR(5), .N_SYNC(4), .N_OVF(1), .DEBOUNCE(1), .MIN_HOLD(1), .ERR_STICKY(1)) u_fast (
        .clk(clk), .reset_n(reset_n), .error_in(error_in), .sync_lost_in(sync_lost_in),
        .busy_in(busy_in), .ovf_warn_in(ovf_warn_in), .clear(clear),
        .tts_state(tts_c), .err_cause(cause_c), .transition_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] err;
        logic [3:0] sync;
        logic       busy;
        logic       ovf;
        logic       clr;
        int         cycles;
        logic [3:0] exp_tts;
        int         exp_cnt;
        logic [4:0] exp_cause;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [4:0] e, logic [3:0] s, logic b, logic o, logic c,
                                int n, logic [3:0] t, int k, logic [4:0] ca);
        vec_t v;
        v.err = e; v.sync = s; v.busy = b; v.ovf = o; v.clr = c;
        v.cycles = n; v.exp_tts = t; v.exp_cnt = k; v.exp_cause = ca;
        return v;
    endfunction

    // Reference model: state is a priority rank (5 error .. 1 ready, 0 disconnected)
    // plus the number of cycles spent in it.
    int         m_cnt [3][4];
    bit         m_latch [3];
    logic [4:0] m_cause [3];
    int         m_tc [3];
    int         m_rank [3];
    int         m_age [3];

    function automatic int deb_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int hold_of(int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic bit sticky_of(int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [3:0] code_of(int r);
        case (r)
            5:       return 4'b1100;
            4:       return 4'b0010;
            3:       return 4'b0100;
            2:       return 4'b0001;
            1:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
            m_latch[i] = 1'b0;
            m_cause[i] = '0;
            m_tc[i]    = 0;
            m_rank[i]  = 0;
            m_age[i]   = 1 << 20;
        end
    endtask

    task automatic modelStep();
        bit         raw [4];
        bit         act [4];
        bit         err_on;
        bit         chg;
        int         tgt;
        logic [4:0] seen;
        raw[0] = |error_in;
        raw[1] = |sync_lost_in;
        raw[2] = busy_in;
        raw[3] = ovf_warn_in[0];
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 4; c++) act[c] = (m_cnt[i][c] == deb_of(i));
            err_on = act[0] || (sticky_of(i) && m_latch[i]);
            tgt = err_on ? 5 : act[1] ? 4 : act[2] ? 3 : act[3] ? 2 : 1;
            chg = (tgt > m_rank[i]) || ((tgt < m_rank[i]) && (m_age[i] >= hold_of(i) - 1));
            seen = err_on ? error_in : 5'b0;
            m_cause[i] = clear ? seen : (m_cause[i] | seen);
            if (clear)
                m_tc[i] = chg ? 1 : 0;
            else if (chg && m_tc[i] < 65535)
                m_tc[i] = m_tc[i] + 1;
            if (sticky_of(i)) begin
                if (clear && !raw[0]) m_latch[i] = 1'b0;
                else if (act[0])      m_latch[i] = 1'b1;
            end
            if (chg) begin
                m_rank[i] = tgt;
                m_age[i]  = 0;
            end else if (m_age[i] < (1 << 20)) begin
                m_age[i] = m_age[i] + 1;
            end
            for (int c = 0; c < 4; c++)
                m_cnt[i][c] = raw[c] ? ((m_cnt[i][c] < deb_of(i)) ? m_cnt[i][c] + 1 : m_cnt[i][c]) : 0;
        end
    endtask

    task automatic checkOutput(string name, int inst, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s inst=%0d got=%0h want=%0h at %0t", name, inst, actual, expected, $time);
        end
    endtask

    task automatic checkInst(int i, logic [3:0] t, logic [4:0] ca, logic [15:0] k);
        checkOutput("model_tts", i, 32'(t), 32'(code_of(m_rank[i])));
        checkOutput("model_cause", i, 32'(ca), 32'(m_cause[i]));
        checkOutput("model_count", i, 32'(k), 32'(m_tc[i]));
    endtask

    task automatic checkAll();
        checkInst(0, tts_a, cause_a, cnt_a);
        checkInst(1, tts_b, cause_b, cnt_b);
        checkInst(2, tts_c, cause_c, cnt_c);
    endtask

    task automatic applyStimulus(logic [4:0] e, logic [3:0] s, logic b, logic o, logic c);
        error_in       = e;
        sync_lost_in   = s;
        busy_in        = b;
        ovf_warn_in[0] = o;
        clear          = c;
    endtask

    task automatic runCycle(bit chk);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (chk) checkAll();
    endtask

    // Asserts reset between edges so the async path is what clears the outputs.
    task automatic doReset();
        #2;
        reset_n = 1'b0;
        applyStimulus(5'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        #1;
        modelReset();
        checkOutput("rst_tts", 0, 32'(tts_a), 32'h0);
        checkOutput("rst_tts", 1, 32'(tts_b), 32'h0);
        checkOutput("rst_tts", 2, 32'(tts_c), 32'h0);
        checkOutput("rst_cause", 0, 32'(cause_a), 32'h0);
        checkOutput("rst_count", 0, 32'(cnt_a), 32'h0);
        checkOutput("rst_count", 2, 32'(cnt_c), 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_hold_tts", 0, 32'(tts_a), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] e;
        logic [3:0] s;
        logic       b;
        logic       o;
        logic       c;
        int         seg;

        //          err       sync     bsy  ovf  clr  n   tts      cnt cause
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 3,  4'b1000, 1, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0100, 1'b0, 1'b0, 1'b0, 3,  4'b1000, 1, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  4'b1000, 1, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0100, 1'b0, 1'b0, 1'b0, 4,  4'b1000, 1, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0100, 1'b0, 1'b0, 1'b0, 1,  4'b0010, 2, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 7,  4'b0010, 2, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  4'b1000, 3, 5'b00000));
        tbl.push_back(mk(5'b00001, 4'b0000, 1'b0, 1'b0, 1'b0, 6,  4'b1100, 4, 5'b00001));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 10, 4'b1100, 4, 5'b00001));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b1, 1,  4'b1100, 0, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  4'b1000, 1, 5'b00000));
        tbl.push_back(mk(5'b00100, 4'b0000, 1'b0, 1'b0, 1'b0, 6,  4'b1100, 2, 5'b00100));
        tbl.push_back(mk(5'b00100, 4'b0000, 1'b0, 1'b0, 1'b1, 1,  4'b1100, 0, 5'b00100));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 12, 4'b1100, 0, 5'b00100));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b1, 1,  4'b1100, 0, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  4'b1000, 1, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 6,  4'b0001, 2, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 6,  4'b0001, 2, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  4'b1000, 3, 5'b00000));
        tbl.push_back(mk(5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 6,  4'b0001, 4, 5'b00000));
        tbl.push_back(mk(5'b10000, 4'b0000, 1'b0, 1'b0, 1'b0, 4,  4'b0001, 4, 5'b00000));
        tbl.push_back(mk(5'b10000, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  4'b1100, 5, 5'b10000));

        reset_n = 1'b0;
        applyStimulus(5'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        doReset();

        foreach (tbl[k]) begin
            applyStimulus(tbl[k].err, tbl[k].sync, tbl[k].busy, tbl[k].ovf, tbl[k].clr);
            repeat (tbl[k].cycles) runCycle(1'b1);
            checkOutput("tbl_tts", k, 32'(tts_a), 32'(tbl[k].exp_tts));
            checkOutput("tbl_count", k, 32'(cnt_a), 32'(tbl[k].exp_cnt));
            checkOutput("tbl_cause", k, 32'(cause_a), 32'(tbl[k].exp_cause));
        end

        // Non-sticky unwinding: error -> sync-lost -> busy -> ready, one transition per step.
        doReset();
        applyStimulus(5'b00010, 4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (6) runCycle(1'b1);
        checkOutput("unwind_err_tts", 1, 32'(tts_b), 32'hC);
        checkOutput("unwind_err_cnt", 1, 32'(cnt_b), 32'd2);
        checkOutput("unwind_err_tts", 0, 32'(tts_a), 32'hC);
        applyStimulus(5'b00000, 4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (20) runCycle(1'b1);
        checkOutput("unwind_sync_tts", 1, 32'(tts_b), 32'h2);
        checkOutput("unwind_sync_cnt", 1, 32'(cnt_b), 32'd3);
        checkOutput("unwind_sticky_tts", 0, 32'(tts_a), 32'hC);
        checkOutput("unwind_sticky_cnt", 0, 32'(cnt_a), 32'd2);
        applyStimulus(5'b00000, 4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (20) runCycle(1'b1);
        checkOutput("unwind_busy_tts", 1, 32'(tts_b), 32'h4);
        checkOutput("unwind_busy_cnt", 1, 32'(cnt_b), 32'd4);
        applyStimulus(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (20) runCycle(1'b1);
        checkOutput("unwind_ready_tts", 1, 32'(tts_b), 32'h8);
        checkOutput("unwind_ready_cnt", 1, 32'(cnt_b), 32'd5);

        // Toggle the overflow warning every cycle to push the fast instance past 16 bits of transitions.
        doReset();
        for (int n = 0; n < 66000; n++) begin
            applyStimulus(5'b0, 4'b0, 1'b0, n[0], 1'b0);
            runCycle((n % 4096) == 0);
        end
        applyStimulus(5'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) runCycle(1'b1);
        checkOutput("sat_count", 2, 32'(cnt_c), 32'hFFFF);
        checkOutput("sat_quiet", 0, 32'(cnt_a), 32'd1);
        applyStimulus(5'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        runCycle(1'b1);
        checkOutput("sat_clear", 2, 32'(cnt_c), 32'h0);

        // Random segments of held inputs with occasional clears and one mid-run reset.
        applyStimulus(5'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        e = '0; s = '0; b = 1'b0; o = 1'b0;
        seg = 0;
        for (int n = 0; n < 3000; n++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 12);
                e = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
                s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
                b = ($urandom_range(0, 2) == 0);
                o = ($urandom_range(0, 2) == 0);
            end
            seg--;
            c = ($urandom_range(0, 40) == 0);
            applyStimulus(e, s, b, o, c);
            runCycle(1'b1);
            if (n == 1500) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
